// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: shared multi-cycle double-dabble binary-to-BCD converter.
// Two requesters are served through a round-robin arbiter. One binary bit is
// consumed per clock. Each result is tagged with the ID of the requester it
// belongs to and is held on the output until the consumer accepts it.
// Optional feature: define BCD_FAST_PATH_EN to bypass the shift loop for
// values below 10. Those values then complete one cycle after accept.
module bcd_conv_scheduler #(
  parameter int BIN_W  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [BIN_W-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [BIN_W-1:0]      req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_tag,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // The largest binary input must fit in the available decimal digits.
  if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_digits_too_small
    $error("bcd_conv_scheduler: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tag_q;
  logic               last_grant_q;
`ifdef BCD_FAST_PATH_EN
  logic               fast_q;
`endif

  logic               grant0;
  logic               grant1;
  logic [BIN_W-1:0]   sel_data;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic               cnt_last;

  // Double-dabble correction of a single digit: add 3 when the digit is 5 or more.
  function automatic logic [3:0] digit_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Apply the digit correction to all digits in parallel.
  function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = digit_adj(b[4*i +: 4]);
    return r;
  endfunction

  // Round-robin grant: a lone requester wins, and a tie goes to the one not served last.
  always_comb begin
    grant0   = req0_valid & (~req1_valid | last_grant_q);
    grant1   = req1_valid & (~req0_valid | ~last_grant_q);
    sel_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  // One double-dabble step: correct the digits, then shift {bcd, bin} left by one bit.
  always_comb begin
    bcd_corr  = bcd_adj(bcd_q);
    bcd_shift = {bcd_corr[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_shift = {bin_q[BIN_W-2:0], 1'b0};
    cnt_last  = (cnt_q == CNT_W'(BIN_W - 1));
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      tag_q        <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef BCD_FAST_PATH_EN
      fast_q       <= 1'b0;
`endif
      out_valid    <= 1'b0;
      out_bcd      <= '0;
      out_tag      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            bin_q        <= sel_data;
            bcd_q        <= '0;
            cnt_q        <= '0;
            tag_q        <= req1_ready;
            last_grant_q <= req1_ready;
`ifdef BCD_FAST_PATH_EN
            fast_q       <= (32'(sel_data) < 32'd10);
`endif
            busy         <= 1'b1;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
`ifdef BCD_FAST_PATH_EN
          if (fast_q) begin
            bcd_q     <= BCD_W'(bin_q);
            out_bcd   <= BCD_W'(bin_q);
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
`endif
            bcd_q <= bcd_shift;
            bin_q <= bin_shift;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_last) begin
              out_bcd   <= bcd_shift;
              out_tag   <= tag_q;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
`ifdef BCD_FAST_PATH_EN
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_tag   <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Testbench for bcd_conv_scheduler: randomized and directed stimulus with a
// queue-based scoreboard checked against a decimal-arithmetic reference model.
module tb_bcd_conv_scheduler;

  localparam int BIN_W  = 5;
  localparam int DIGITS = 2;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [BIN_W-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [BCD_W-1:0] out_bcd;
  logic             out_tag;
  logic             out_ready;
  logic             busy;

  bcd_conv_scheduler #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_bcd(out_bcd), .out_tag(out_tag),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic             tag;
    int               acc;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_grant_m = 1;
  bit   rand_rdy = 1'b0;
  bit   mon_prev = 1'b0;

  // Reference: decimal digits by division, ones digit in the low nibble.
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int ref_lat(input int v);
`ifdef BCD_FAST_PATH_EN
    if (v < 10) return 2;
`endif
    return BIN_W + 1;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data and tag on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_prev <= 1'b0;
    end else begin
      if (out_valid && !mon_prev) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_bcd", int'(out_bcd), int'(e.bcd));
        chk("out_tag", int'(out_tag), int'(e.tag));
      end
      mon_prev <= out_valid;
    end
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present a request pattern, wait for the accept, check the grant against the model.
  task automatic issue(input bit v0, input int d0, input bit v1, input int d1);
    int win, n, d;
    req0_valid = v0; req0_data = BIN_W'(d0);
    req1_valid = v1; req1_data = BIN_W'(d1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req0_ready || req1_ready) && n < 200);
    if (!(req0_ready || req1_ready)) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    win = (v0 && v1) ? ((last_grant_m == 1) ? 0 : 1) : (v0 ? 0 : 1);
    chk("grant0", int'(req0_ready), int'(win == 0));
    chk("grant1", int'(req1_ready), int'(win == 1));
    d = win ? d1 : d0;
    exp_q.push_back('{ref_bcd(d), win[0], cyc, ref_lat(d)});
    last_grant_m = win;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    last_grant_m = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bcd", int'(out_bcd), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_req1_ready", int'(req1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sweep all values from requester 0, with occasional idle gaps.
    for (int v = 0; v < 32; v++) begin
      issue(1'b1, v, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) begin
        req0_valid = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    idle_reqs();
    drain();

    // Tie arbitration from reset: requester 0 first, then 1, and again 0 first.
    do_reset();
    issue(1'b1, 7, 1'b1, 19);
    issue(1'b0, 0, 1'b1, 19);
    issue(1'b1, 12, 1'b1, 25);
    issue(1'b0, 0, 1'b1, 25);
    idle_reqs();
    drain();

    // Alternation with both requesters continuously valid.
    for (int i = 0; i < 4; i++)
      issue(1'b1, int'($urandom_range(0, 31)), 1'b1, int'($urandom_range(0, 31)));
    idle_reqs();
    drain();

    // Backpressure: result held stable, no accepts while DONE.
    out_ready = 1'b0;
    issue(1'b1, 23, 1'b0, 0);
    idle_reqs();
    wait_out_valid();
    req1_valid = 1'b1;
    req1_data  = BIN_W'(11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_bcd", int'(out_bcd), 'h23);
      chk("bp_out_tag", int'(out_tag), 0);
      chk("bp_req0_ready", int'(req0_ready), 0);
      chk("bp_req1_ready", int'(req1_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(1'b0, 0, 1'b1, 11);
    idle_reqs();
    drain();

    // Reset in the third SHIFT cycle, then a clean conversion.
    issue(1'b1, 29, 1'b0, 0);
    idle_reqs();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_grant_m = 1;
    #1;
    chk("rst_shift_out_valid", int'(out_valid), 0);
    chk("rst_shift_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 16, 1'b0, 0);
    idle_reqs();
    drain();

    // Reset while a result is waiting in DONE.
    out_ready = 1'b0;
    issue(1'b1, 29, 1'b0, 0);
    idle_reqs();
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_grant_m = 1;
    #1;
    chk("rst_done_out_valid", int'(out_valid), 0);
    chk("rst_done_out_bcd", int'(out_bcd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Input hold: data changes after accept must not affect the result.
    issue(1'b1, 30, 1'b0, 0);
    req0_data  = BIN_W'(5);
    req0_valid = 1'b0;
    drain();

    // Random requests with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      issue(v0, int'($urandom_range(0, 31)), v1, int'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        idle_reqs();
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1;
      end
    end
    idle_reqs();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Multi-cycle double-dabble binary-to-BCD engine, shared between two requesters through a round-robin arbiter.
- Converts one binary bit per clock, replacing the flat combinational converter wherever timing or area matters.
- Sits between producers of binary counts (e.g. event counters) and display/report logic.
- Results return on a single output channel, tagged with the requester ID.

Parameters:
- BIN_W, 5: binary input width.
- DIGITS, 2: number of BCD digits. Must satisfy 10^DIGITS > 2^BIN_W-1; checked at elaboration, which fails otherwise.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a value.
- req0_data  input  BIN_W  requester 0 binary value.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid  input  1  requester 1 has a value.
- req1_data  input  BIN_W  requester 1 binary value.
- req1_ready  output  1  requester 1 accepted this cycle.
- out_valid  output  1  result available.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- out_tag  output  1  requester ID of the result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0.
  - Internal shift and BCD registers cleared.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - reqK_ready is combinational: high only in IDLE, for the granted requester only.
  - Grant rule: a lone valid requester is granted. If both are valid, grant the requester != last_grant.
  - On accept (reqK_valid & reqK_ready): load binary shift register with reqK_data, clear BCD register, latch tag=K, set last_grant=K, bit counter=0, go to SHIFT.
  - At most one request is accepted per cycle.
- SHIFT, once per cycle:
  - Add 3 to every BCD digit >= 5.
  - Shift {bcd, bin} left by 1; the binary MSB enters bcd bit 0.
  - Increment the counter. After the BIN_W-th shift, go to DONE.
- Latency: accept edge at cycle N gives out_valid=1 from cycle N+BIN_W+1 (5+1=6 edges for default). Every value takes fixed latency; no data-dependent early exit unless the optional feature is enabled.
- DONE:
  - out_valid=1; out_bcd and out_tag stable and held until out_ready=1.
  - On out_valid & out_ready: go to IDLE. The result clears at the next edge.
  - A new request cannot be accepted in the same cycle as result consumption; the earliest accept is the following IDLE cycle.
- Requester-side rules:
  - Requesters must hold valid and data until ready.
  - Data changes while not granted are ignored.
  - reqK_data is sampled only at the accept edge; later changes do not affect the conversion in flight.
- Arithmetic: digit correction is 4-bit, applied to all DIGITS digits in parallel before the shift. With all-ones input of width BIN_W, no digit exceeds 9 at completion.
- Reset mid-operation: rst_n low in SHIFT or DONE aborts immediately. The pending result is discarded, out_valid drops asynchronously, and last_grant returns to 1.
- busy = (state != IDLE).

Optional Feature:
- Macro BCD_FAST_PATH_EN.
  - When defined: an accepted value < 10 skips SHIFT. The BCD register loads {0…, value[3:0]} directly and the FSM goes to DONE; out_valid is high 1 cycle after the accept edge. Values >= 10 use the normal BIN_W-cycle path.
  - When undefined: all values take BIN_W+1 cycles; no comparator is synthesized.

Test Plan:
- Sweep: requester 0 submits each value 0..31, out_ready=1. Each result must satisfy out_bcd == {v/10, v%10}, e.g. 31 gives 8'h31 and 19 gives 8'h19. out_tag=0. Latency is 6 edges (2 for v<10 with BCD_FAST_PATH_EN).
- Tie arbitration: first, both requesters valid with req0=7 and req1=19, held. Required: req0 granted first (8'h07, tag 0), then req1 (8'h19, tag 1). Second, both valid with 12 and 25. Required: req0 served first again, because last_grant=1.
- Alternation: both requesters stay valid continuously for 4 conversions. Required: tags 0,1,0,1, never the same requester twice in a row.
- Backpressure: out_ready=0 for 10 cycles after a conversion of 23. Required: out_valid, out_bcd=8'h23 and out_tag stay stable; reqK_ready stays 0 throughout. out_ready=1 gives one handshake, then IDLE.
- Reset mid-conversion: convert 29, drop rst_n in the 3rd SHIFT cycle. Required: out_valid=0 and busy=0 immediately. Next conversion of 16 returns 8'h16 with correct latency.
- Input hold: change req0_data from 30 to 5 on the cycle after accept. Required: the result is still 8'h30.
